// File: rtl/mcycle_ctrl_pkg.sv
// rtl/mcycle_ctrl_pkg.sv - state, op and result-select encodings for the MUL/DIV sequencer
package mcycle_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } mc_state_t;

  // Op[1] selects divide, Op[0] selects the unsigned variant
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULU = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  localparam logic RESSEL_LO = 1'b0;
  localparam logic RESSEL_HI = 1'b1;

endpackage

// File: rtl/mcycle_ctrl_reuse_cache.sv
// rtl/mcycle_ctrl_reuse_cache.sv - last-completed operation tag compare and result store
module mcycle_ctrl_reuse_cache #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_update,
  input  logic             i_clear,
  input  logic [1:0]       i_upd_op,
  input  logic [WIDTH-1:0] i_upd_operand1,
  input  logic [WIDTH-1:0] i_upd_operand2,
  input  logic [WIDTH-1:0] i_upd_result1,
  input  logic [WIDTH-1:0] i_upd_result2,
  input  logic [1:0]       i_lk_op,
  input  logic [WIDTH-1:0] i_lk_operand1,
  input  logic [WIDTH-1:0] i_lk_operand2,
  output logic             o_hit,
  output logic [WIDTH-1:0] o_result1,
  output logic [WIDTH-1:0] o_result2
);

  logic             r_valid;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_operand1;
  logic [WIDTH-1:0] r_operand2;
  logic [WIDTH-1:0] r_result1;
  logic [WIDTH-1:0] r_result2;

  // Store the tag and both result halves of each completed op; a killed op invalidates the entry
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid    <= 1'b0;
      r_op       <= '0;
      r_operand1 <= '0;
      r_operand2 <= '0;
      r_result1  <= '0;
      r_result2  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_update) begin
      r_valid    <= 1'b1;
      r_op       <= i_upd_op;
      r_operand1 <= i_upd_operand1;
      r_operand2 <= i_upd_operand2;
      r_result1  <= i_upd_result1;
      r_result2  <= i_upd_result2;
    end
  end

  assign o_hit     = r_valid && (r_op == i_lk_op) && (r_operand1 == i_lk_operand1)
                     && (r_operand2 == i_lk_operand2);
  assign o_result1 = r_result1;
  assign o_result2 = r_result2;

endmodule

// File: rtl/mcycle_ctrl.sv
// rtl/mcycle_ctrl.sv - EX-stage MUL/DIV sequencer; optional result reuse under MCYCLE_REUSE_EN
module mcycle_ctrl
  import mcycle_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic             i_result_sel,
  input  logic [WIDTH-1:0] i_operand1,
  input  logic [WIDTH-1:0] i_operand2,
  input  logic             i_flush,
  input  logic             i_hold,
  input  logic             i_mc_done,
  input  logic [WIDTH-1:0] i_mc_result1,
  input  logic [WIDTH-1:0] i_mc_result2,
  output logic             o_mc_start,
  output logic [1:0]       o_mc_op,
  output logic [WIDTH-1:0] o_mc_operand1,
  output logic [WIDTH-1:0] o_mc_operand2,
  output logic             o_stall,
  output logic [WIDTH-1:0] o_result,
  output logic             o_result_valid
);

  mc_state_t        r_state;
  logic             r_mc_start;
  logic [1:0]       r_mc_op;
  logic [WIDTH-1:0] r_mc_operand1;
  logic [WIDTH-1:0] r_mc_operand2;
  logic             r_result_sel;
  logic [WIDTH-1:0] r_res1;
  logic [WIDTH-1:0] r_res2;

  logic             w_hit;
  logic [WIDTH-1:0] w_hit_r1;
  logic [WIDTH-1:0] w_hit_r2;
  logic             w_req;
  logic             w_reuse;
  logic             w_issue;

  // A live request in IDLE either reuses the stored result or goes to the unit
  assign w_req   = (r_state == ST_IDLE) && i_start && !i_flush;
  assign w_reuse = w_req && w_hit;
  assign w_issue = w_req && !w_hit;

`ifdef MCYCLE_REUSE_EN
  logic w_done_entry;
  logic w_drain_entry;

  assign w_done_entry  = (r_state == ST_BUSY) && i_mc_done && !i_flush;
  assign w_drain_entry = (r_state == ST_BUSY) && i_flush && !i_mc_done;

  mcycle_ctrl_reuse_cache #(.WIDTH(WIDTH)) u_reuse (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_update       (w_done_entry),
    .i_clear        (w_drain_entry),
    .i_upd_op       (r_mc_op),
    .i_upd_operand1 (r_mc_operand1),
    .i_upd_operand2 (r_mc_operand2),
    .i_upd_result1  (i_mc_result1),
    .i_upd_result2  (i_mc_result2),
    .i_lk_op        (i_op),
    .i_lk_operand1  (i_operand1),
    .i_lk_operand2  (i_operand2),
    .o_hit          (w_hit),
    .o_result1      (w_hit_r1),
    .o_result2      (w_hit_r2)
  );
`else
  assign w_hit    = 1'b0;
  assign w_hit_r1 = '0;
  assign w_hit_r2 = '0;
`endif

  // Sequencer: issue one op at a time, wait for done, present result, drain killed ops
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_mc_start    <= 1'b0;
      r_mc_op       <= '0;
      r_mc_operand1 <= '0;
      r_mc_operand2 <= '0;
      r_result_sel  <= 1'b0;
      r_res1        <= '0;
      r_res2        <= '0;
    end else begin
      r_mc_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_mc_start    <= 1'b1;
            r_mc_op       <= i_op;
            r_mc_operand1 <= i_operand1;
            r_mc_operand2 <= i_operand2;
            r_result_sel  <= i_result_sel;
            r_state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (i_mc_done && i_flush) begin
            r_state <= ST_IDLE;
          end else if (i_mc_done) begin
            r_res1  <= i_mc_result1;
            r_res2  <= i_mc_result2;
            r_state <= ST_DONE;
          end else if (i_flush) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          if (i_flush || !i_hold) begin
            r_state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (i_mc_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stall covers the issue cycle, the whole busy window, and a new op waiting out a drain
  always_comb begin
    o_stall = 1'b0;
    case (r_state)
      ST_IDLE:  o_stall = w_issue;
      ST_BUSY:  o_stall = !i_flush;
      ST_DONE:  o_stall = 1'b0;
      ST_DRAIN: o_stall = i_start && !i_flush;
      default:  o_stall = 1'b0;
    endcase
  end

  // Result is the selected half of the captured or reused pair, zero when not valid
  always_comb begin
    o_result_valid = 1'b0;
    o_result       = '0;
    if (r_state == ST_DONE) begin
      o_result_valid = 1'b1;
      o_result       = (r_result_sel == RESSEL_HI) ? r_res2 : r_res1;
    end else if (w_reuse) begin
      o_result_valid = 1'b1;
      o_result       = (i_result_sel == RESSEL_HI) ? w_hit_r2 : w_hit_r1;
    end
  end

  assign o_mc_start    = r_mc_start;
  assign o_mc_op       = r_mc_op;
  assign o_mc_operand1 = r_mc_operand1;
  assign o_mc_operand2 = r_mc_operand2;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// tb/tb_mcycle_ctrl.sv - randomized self-checking bench for mcycle_ctrl with a behavioural unit
module tb_mcycle_ctrl;
  import mcycle_ctrl_pkg::*;

`ifdef MCYCLE_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic [1:0]  i_op;
  logic        i_result_sel;
  logic [31:0] i_operand1;
  logic [31:0] i_operand2;
  logic        i_flush;
  logic        i_hold;
  logic        i_mc_done;
  logic [31:0] i_mc_result1;
  logic [31:0] i_mc_result2;
  logic        o_mc_start;
  logic [1:0]  o_mc_op;
  logic [31:0] o_mc_operand1;
  logic [31:0] o_mc_operand2;
  logic        o_stall;
  logic [31:0] o_result;
  logic        o_result_valid;

  mcycle_ctrl #(.WIDTH(32)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_op           (i_op),
    .i_result_sel   (i_result_sel),
    .i_operand1     (i_operand1),
    .i_operand2     (i_operand2),
    .i_flush        (i_flush),
    .i_hold         (i_hold),
    .i_mc_done      (i_mc_done),
    .i_mc_result1   (i_mc_result1),
    .i_mc_result2   (i_mc_result2),
    .o_mc_start     (o_mc_start),
    .o_mc_op        (o_mc_op),
    .o_mc_operand1  (o_mc_operand1),
    .o_mc_operand2  (o_mc_operand2),
    .o_stall        (o_stall),
    .o_result       (o_result),
    .o_result_valid (o_result_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  // behavioural unit and observation state
  bit          unit_busy = 1'b0;
  int          unit_cnt = 0;
  int          unit_lat = 4;
  logic [31:0] unit_r1, unit_r2;
  int          mc_start_count = 0;
  bit          stray_done = 1'b0;
  logic        s_stall, s_valid, s_mc_start;
  logic [31:0] s_result;

  // reuse model: last op that completed through the unit
  bit          last_valid = 1'b0;
  logic [1:0]  last_op;
  logic [31:0] last_a, last_b;

  function automatic logic [31:0] ref_result(logic [1:0] op, logic [31:0] a, logic [31:0] b, logic sel);
    logic [63:0] p;
    logic [31:0] q, r;
    if (!op[1]) begin
      if (!op[0]) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      else        p = {32'b0, a} * {32'b0, b};
      return sel ? p[63:32] : p[31:0];
    end
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return sel ? r : q;
  endfunction

  // one clock cycle: unit drives done, sample DUT, advance unit, cross the edge
  task automatic tick();
    if (unit_busy && unit_cnt == 0) begin
      i_mc_done = 1'b1;
      i_mc_result1 = unit_r1;
      i_mc_result2 = unit_r2;
    end else if (stray_done) begin
      i_mc_done = 1'b1;
      i_mc_result1 = 32'hDEAD_BEEF;
      i_mc_result2 = 32'h0BAD_F00D;
    end else begin
      i_mc_done = 1'b0;
    end
    #1;
    s_stall = o_stall;
    s_valid = o_result_valid;
    s_result = o_result;
    s_mc_start = o_mc_start;
    if (i_reset) begin
      unit_busy = 1'b0;
    end else begin
      if (unit_busy && i_mc_done) unit_busy = 1'b0;
      else if (unit_busy) unit_cnt--;
      if (s_mc_start) begin
        checks++;
        if (unit_busy) begin
          failures++;
          $display("FAIL double_issue: mc_start=1 while unit busy (cnt=%0d), required no start", unit_cnt);
        end
        mc_start_count++;
        unit_busy = 1'b1;
        unit_cnt = unit_lat - 1;
        unit_r1 = ref_result(o_mc_op, o_mc_operand1, o_mc_operand2, 1'b0);
        unit_r2 = ref_result(o_mc_op, o_mc_operand1, o_mc_operand2, 1'b1);
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  // run one instruction through EX until it leaves, checking stall count, result and start count
  task automatic run_instr(string name, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                           logic sel, int lat, int h);
    logic [31:0] exp;
    bit hit;
    int exp_stall, stalls, vc, cyc, starts0;
    exp = ref_result(op, a, b, sel);
    hit = REUSE && last_valid && last_op == op && last_a == a && last_b == b;
    exp_stall = hit ? 0 : lat + 2;
    unit_lat = lat;
    starts0 = mc_start_count;
    i_start = 1'b1; i_op = op; i_operand1 = a; i_operand2 = b; i_result_sel = sel;
    i_flush = 1'b0; i_hold = (h > 0);
    stalls = 0; vc = 0; cyc = 0;
    while (vc < h + 1 && cyc < 60) begin
      tick();
      cyc++;
      if (s_valid) begin
        vc++;
        checks++;
        if (s_result !== exp || s_stall !== 1'b0) begin
          failures++;
          $display("FAIL %s result: got %h stall=%b, required %h stall=0", name, s_result, s_stall, exp);
        end
        if (vc == h) i_hold = 1'b0;
      end else if (s_stall) begin
        stalls++;
      end else begin
        checks++;
        failures++;
        $display("FAIL %s idle_gap: stall=0 valid=0 at cycle %0d, required stall or valid", name, cyc);
      end
    end
    checks++;
    if (cyc >= 60) begin
      failures++;
      $display("FAIL %s timeout: %0d valid cycles, required %0d", name, vc, h + 1);
    end
    checks++;
    if (stalls != exp_stall) begin
      failures++;
      $display("FAIL %s stall_cycles: got %0d, required %0d", name, stalls, exp_stall);
    end
    checks++;
    if (mc_start_count - starts0 != (hit ? 0 : 1)) begin
      failures++;
      $display("FAIL %s start_count: got %0d, required %0d", name, mc_start_count - starts0, hit ? 0 : 1);
    end
    if (!hit) begin
      last_valid = 1'b1; last_op = op; last_a = a; last_b = b;
    end
    i_start = 1'b0;
    i_hold = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    checks++;
    if (o_stall !== 1'b0 || o_result_valid !== 1'b0 || o_mc_start !== 1'b0 || o_mc_op !== 2'b00 ||
        o_mc_operand1 !== 32'd0 || o_mc_operand2 !== 32'd0 || o_result !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: stall=%b valid=%b start=%b op=%b a=%h b=%h res=%h, required all 0",
               o_stall, o_result_valid, o_mc_start, o_mc_op, o_mc_operand1, o_mc_operand2, o_result);
    end
    last_valid = 1'b0;
  endtask

  task automatic test_mul_basic();
    run_instr("mul_7x-3", OP_MUL, 32'd7, 32'hFFFF_FFFD, RESSEL_LO, 4, 0);
    checks++;
    if (s_result !== 32'hFFFF_FFEB) begin
      failures++;
      $display("FAIL mul_7x-3 const: got %h, required ffffffeb", s_result);
    end
  endtask

  task automatic test_divu();
    run_instr("divu_rem", OP_DIVU, 32'd100, 32'd7, RESSEL_HI, 5, 0);
    checks++;
    if (s_result !== 32'd2) begin
      failures++;
      $display("FAIL divu_rem const: got %0d, required 2", s_result);
    end
    run_instr("divu_quo", OP_DIVU, 32'd100, 32'd7, RESSEL_LO, 5, 0);
    checks++;
    if (s_result !== 32'd14) begin
      failures++;
      $display("FAIL divu_quo const: got %0d, required 14", s_result);
    end
  endtask

  task automatic test_hold();
    run_instr("hold3", OP_MULU, 32'h1234_5678, 32'h9ABC_DEF0, RESSEL_HI, 3, 3);
  endtask

  task automatic test_flush_idle();
    i_start = 1'b1; i_op = OP_MUL; i_operand1 = 32'd11; i_operand2 = 32'd13; i_flush = 1'b1;
    tick();
    checks++;
    if (s_stall !== 1'b0 || s_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle: stall=%b valid=%b, required 0 0", s_stall, s_valid);
    end
    i_start = 1'b0; i_flush = 1'b0;
    tick();
    checks++;
    if (s_mc_start !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_start: mc_start=%b, required 0", s_mc_start);
    end
  endtask

  task automatic test_flush_drain();
    int starts0, cyc;
    bit seen;
    starts0 = mc_start_count;
    unit_lat = 5;
    i_start = 1'b1; i_op = OP_MUL; i_operand1 = 32'd9; i_operand2 = 32'd9;
    i_result_sel = RESSEL_LO; i_flush = 1'b0; i_hold = 1'b0;
    cyc = 0;
    while (mc_start_count == starts0 && cyc < 10) begin
      tick();
      cyc++;
    end
    unit_lat = 3;
    tick();
    i_flush = 1'b1;
    tick();
    last_valid = 1'b0;
    checks++;
    if (s_stall !== 1'b0 || s_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy: stall=%b valid=%b, required 0 0", s_stall, s_valid);
    end
    i_flush = 1'b0; i_operand1 = 32'd3; i_operand2 = 32'd5;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 40) begin
      tick();
      cyc++;
      if (s_valid) begin
        seen = 1'b1;
        checks++;
        if (s_result !== 32'd15) begin
          failures++;
          $display("FAIL drain_result: got %h, required 0000000f", s_result);
        end
      end else if (!s_stall) begin
        checks++;
        failures++;
        $display("FAIL drain_stall: stall=0 at cycle %0d, required 1", cyc);
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL drain_timeout: no valid within 40 cycles, required valid");
    end
    checks++;
    if (mc_start_count - starts0 != 2) begin
      failures++;
      $display("FAIL drain_starts: got %0d, required 2", mc_start_count - starts0);
    end
    last_valid = 1'b1; last_op = OP_MUL; last_a = 32'd3; last_b = 32'd5;
    i_start = 1'b0;
  endtask

  task automatic test_reset_busy();
    int starts0, cyc;
    starts0 = mc_start_count;
    unit_lat = 6;
    i_start = 1'b1; i_op = OP_DIVU; i_operand1 = 32'd50; i_operand2 = 32'd3;
    i_result_sel = RESSEL_LO; i_flush = 1'b0; i_hold = 1'b0;
    cyc = 0;
    while (mc_start_count == starts0 && cyc < 10) begin
      tick();
      cyc++;
    end
    tick();
    i_reset = 1'b1; i_start = 1'b0;
    tick();
    i_reset = 1'b0;
    last_valid = 1'b0;
    tick();
    checks++;
    if (s_stall !== 1'b0 || s_valid !== 1'b0 || s_mc_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: stall=%b valid=%b start=%b, required 0 0 0", s_stall, s_valid, s_mc_start);
    end
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    checks++;
    if (s_valid !== 1'b0 || s_stall !== 1'b0) begin
      failures++;
      $display("FAIL stray_done: valid=%b stall=%b, required 0 0", s_valid, s_stall);
    end
    tick();
    checks++;
    if (s_valid !== 1'b0 || s_mc_start !== 1'b0) begin
      failures++;
      $display("FAIL stray_after: valid=%b start=%b, required 0 0", s_valid, s_mc_start);
    end
    run_instr("after_reset", OP_DIV, 32'hFFFF_FF9C, 32'd7, RESSEL_HI, 2, 0);
  endtask

  task automatic test_reuse_pair();
    run_instr("mulh_pair", OP_MUL, 32'h8000_0000, 32'd2, RESSEL_HI, 4, 0);
    run_instr("mul_pair", OP_MUL, 32'h8000_0000, 32'd2, RESSEL_LO, 4, 0);
    checks++;
    if (s_result !== 32'h0000_0000) begin
      failures++;
      $display("FAIL mul_pair const: got %h, required 00000000", s_result);
    end
    run_instr("mul_changed", OP_MUL, 32'h8000_0000, 32'd3, RESSEL_LO, 4, 1);
  endtask

  task automatic test_back_to_back();
    logic [1:0] op;
    logic [31:0] a, b;
    op = OP_MUL; a = 32'd1; b = 32'd1;
    for (int n = 0; n < 24; n++) begin
      if (n == 0 || $urandom_range(0, 3) != 0) begin
        op = 2'($urandom_range(0, 3));
        a = $urandom;
        b = $urandom;
        if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      end
      if (op[1] && b == 32'd0) b = 32'd1;
      if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      run_instr("random", op, a, b, 1'($urandom_range(0, 1)), $urandom_range(1, 6), $urandom_range(0, 2));
    end
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_op = 2'b00; i_result_sel = 1'b0;
    i_operand1 = '0; i_operand2 = '0; i_flush = 1'b0; i_hold = 1'b0;
    i_mc_done = 1'b0; i_mc_result1 = '0; i_mc_result2 = '0;
    test_reset();
    test_mul_basic();
    test_divu();
    test_hold();
    test_flush_idle();
    test_flush_drain();
    test_reset_busy();
    test_reuse_pair();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
